width_unpacker: RTL and testbench
=================================

Name: width_unpacker

Overview:
- Receiving end of the parameterized-width datapath. Accepts wide words of WIDTH*RATIO bits over valid/ready and re-emits each one as up to RATIO beats of WIDTH bits.
- Sits downstream of a producer submodule whose data port width is set by WIDTH.
- Supports partial final words and full-throughput back-to-back operation.

Parameters:
- WIDTH, 8, output beat width in bits (>=1).
- RATIO, 4, beats per input word (>=2).
- LSB_FIRST, 1, 1 = beat 0 is in_data[WIDTH-1:0]; 0 = beat 0 is the most-significant slice.
- CW, $clog2(RATIO), derived localparam, index width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  unpacker can accept a word this cycle.
- in_data  input  WIDTH*RATIO  input word.
- in_nbeats_m1  input  CW  number of valid beats in word minus 1 (0..RATIO-1).
- in_last  input  1  word ends a packet.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  current beat.
- out_idx  output  CW  index of current beat within its word.
- out_last  output  1  final beat of a word that had in_last set.

Behaviour:
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_data, in_nbeats_m1 and in_last are sampled only on an input transfer.
- Registers:
  - word_q, nbm1_q, last_q, idx_q (CW bits) and busy_q.
  - States: IDLE (busy_q=0) and SHIFT (busy_q=1).
- Reset: while rst=1 and on the following cycle,
  - busy_q=0, idx_q=0, word_q=0, last_q=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - in_ready is forced 0 while rst=1.
- out_valid = busy_q (registered, no combinational in->out path).
- out_data:
  - Slice idx_q of word_q when LSB_FIRST=1.
  - Slice (RATIO-1-idx_q) of word_q when LSB_FIRST=0.
- out_idx = idx_q.
- out_last = busy_q && last_q && (idx_q == nbm1_q).
- end_beat = out_valid && out_ready && (idx_q == nbm1_q).
- in_ready = !rst && (!busy_q || end_beat). This is the only combinational path, from out_ready to in_ready.
- Transitions:
  - IDLE, input transfer: load the word, set idx_q=0, go to SHIFT. First beat valid the next cycle (latency 1).
  - SHIFT, output transfer with idx_q != nbm1_q: idx_q++.
  - SHIFT, end_beat with no input transfer: go to IDLE, idx_q=0.
  - SHIFT, end_beat with a simultaneous input transfer: load the new word, idx_q=0, stay in SHIFT. No bubble; sustained throughput of one beat per cycle.
  - SHIFT, out_ready=0: all registers hold, and out_data/out_idx/out_last are stable.
- Boundaries:
  - in_nbeats_m1=0 gives a single-beat word.
  - in_nbeats_m1 > RATIO-1 (possible only for non-power-of-2 RATIO) is clamped to RATIO-1.
  - Unused high slices of a partial word are never emitted.
  - idx_q never exceeds nbm1_q; no wrap beyond RATIO-1.
- Reset mid-word: the in-flight word is discarded, with no further beats after rst deasserts.
- in_valid while in_ready=0: no effect. The upstream holds its word per protocol.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> in_ready=0 and out_valid=0 throughout; after release, in_ready=1 and out_valid=0.
- Single full word: WIDTH=8, RATIO=4, LSB_FIRST=1, in_data=32'hDDCCBBAA, nbm1=3, last=1, out_ready=1 -> beats AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after accept; out_idx 0..3; out_last=1 only on DD.
- MSB-first partial word: LSB_FIRST=0, in_data=32'h11223344, nbm1=1, last=0 -> beats 11, 22 only; out_last=0; in_ready=1 during beat 22.
- Back-to-back no bubble: two words 32'h03020100 and 32'h07060504, in_valid held, out_ready=1 -> 8 contiguous beats 00..07; second word accepted on the cycle beat 03 leaves.
- Backpressure: out_ready toggling 1,0,0,1,... during word 32'hDDCCBBAA -> each beat held stable while out_ready=0, no beat skipped or duplicated, in_ready=0 until beat DD transfers.
- Reset mid-word: rst pulsed after beat BB -> no CC/DD emitted; the next word after reset starts at out_idx=0.

Source files
------------

// File: rtl/width_unpacker.sv
// Wide-to-narrow unpacker: takes WIDTH*RATIO-bit words over valid/ready and emits
// up to RATIO beats of WIDTH bits each, with back-to-back reload and no bubble.
module width_unpacker #(
   parameter int WIDTH     = 8,
   parameter int RATIO     = 4,
   parameter int LSB_FIRST = 1,
   localparam int CW       = $clog2(RATIO)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*RATIO-1:0] in_data,
   input  logic [CW-1:0]          in_nbeats_m1,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [CW-1:0]          out_idx,
   output logic                   out_last
);

   // state | meaning
   // IDLE  | no word held, in_ready=1
   // SHIFT | word held, beat idx_q presented on out_*
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [CW-1:0] MAX_IDX = CW'(RATIO - 1);

   logic [WIDTH*RATIO-1:0] word_q;
   logic [CW-1:0]          nbm1_q;
   logic [CW-1:0]          idx_q;
   logic                   last_q;
   logic [0:0]             busy_q;

   logic [CW-1:0]          nbm1_in;
   logic [CW-1:0]          sel;
   logic [WIDTH-1:0]       slice;
   logic                   at_end;
   logic                   out_fire;
   logic                   end_beat;
   logic                   in_fire;

   // Non-power-of-2 RATIO lets the count field exceed the last slice; clamp it.
   assign nbm1_in  = (in_nbeats_m1 > MAX_IDX) ? MAX_IDX : in_nbeats_m1;

   assign at_end   = (idx_q == nbm1_q);
   assign out_fire = (busy_q == SHIFT) && out_ready;
   assign end_beat = out_fire && at_end;
   assign in_ready = !rst && ((busy_q == IDLE) || end_beat);
   assign in_fire  = in_valid && in_ready;

   assign sel   = (LSB_FIRST != 0) ? idx_q : (MAX_IDX - idx_q);
   assign slice = word_q[int'(sel)*WIDTH +: WIDTH];

   // Outputs are forced quiet during reset so the in-flight beat disappears at once.
   assign out_valid = (busy_q == SHIFT) && !rst;
   assign out_data  = rst ? '0 : slice;
   assign out_idx   = rst ? '0 : idx_q;
   assign out_last  = (busy_q == SHIFT) && last_q && at_end && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         nbm1_q <= '0;
         idx_q  <= '0;
         last_q <= 1'b0;
         busy_q <= IDLE;
      end else if (in_fire) begin
         word_q <= in_data;
         nbm1_q <= nbm1_in;
         last_q <= in_last;
         idx_q  <= '0;
         busy_q <= SHIFT;
      end else if (end_beat) begin
         idx_q  <= '0;
         busy_q <= IDLE;
      end else if (out_fire) begin
         idx_q  <= idx_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_width_unpacker.sv
// Self-checking bench for width_unpacker: LSB-first and MSB-first instances share stimulus
// and are checked against a queue-based beat model plus directed timing checks.
module tb_width_unpacker;
   localparam int W  = 8;
   localparam int R  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W*R-1:0] in_data;
   logic [CW-1:0] in_nbeats_m1;
   logic          in_last;
   logic          out_ready;
   logic          in_ready, in_ready_m;
   logic          out_valid_l, out_valid_m;
   logic [W-1:0]  out_data_l, out_data_m;
   logic [CW-1:0] out_idx_l, out_idx_m;
   logic          out_last_l, out_last_m;

   typedef logic [21:0] beat_t;
   beat_t exp_q[$];
   beat_t obs_q[$];
   int    checks = 0;
   int    errors = 0;
   int    mon_n;

   always #5 clk = ~clk;

   width_unpacker #(.WIDTH(W), .RATIO(R), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_nbeats_m1(in_nbeats_m1), .in_last(in_last),
      .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
      .out_idx(out_idx_l), .out_last(out_last_l));

   width_unpacker #(.WIDTH(W), .RATIO(R), .LSB_FIRST(0)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_data(in_data), .in_nbeats_m1(in_nbeats_m1), .in_last(in_last),
      .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
      .out_idx(out_idx_m), .out_last(out_last_m));

   // Reference beat k of an n-beat word, packed as {lsb beat, idx, last, msb beat, idx, last}.
   function automatic beat_t model_beat(logic [W*R-1:0] d, int k, int n, logic l);
      logic [W-1:0] bl, bm;
      logic         lb;
      bl = W'(d >> (W * k));
      bm = W'(d >> (W * (R - 1 - k)));
      lb = l && (k == n - 1);
      return {bl, CW'(k), lb, bm, CW'(k), lb};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      end else begin
         if (in_valid && in_ready) begin
            mon_n = (int'(in_nbeats_m1) > R - 1) ? R : int'(in_nbeats_m1) + 1;
            for (int k = 0; k < mon_n; k++)
               exp_q.push_back(model_beat(in_data, k, mon_n, in_last));
         end
         if (out_valid_l && out_ready)
            obs_q.push_back({out_data_l, out_idx_l, out_last_l, out_data_m, out_idx_m, out_last_m});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = $urandom; in_nbeats_m1 = 2'd3;
      in_last = 1'b0; out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || in_ready_m !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b/%b expected 0", in_ready, in_ready_m);
         end
         checks++;
         if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid_l, out_valid_m);
         end
      end
      tick();
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if ({out_valid_l, out_data_l, out_idx_l, out_last_l} !== '0) begin
         errors++; $display("FAIL post_reset_outputs: got v=%b d=%h i=%0d l=%b expected all 0",
                            out_valid_l, out_data_l, out_idx_l, out_last_l);
      end
   endtask

   task automatic test_single_full();
      logic [W*R-1:0] w;
      tick();
      w = 32'hDDCCBBAA;
      in_valid = 1'b1; in_data = w; in_nbeats_m1 = 2'd3; in_last = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL single_accept: got in_ready=%b expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid_l !== 1'b1 || out_data_l !== W'(w >> (8 * k)) || out_idx_l !== CW'(k)
             || out_last_l !== (k == 3)) begin
            errors++; $display("FAIL single_beat%0d: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                               k, out_valid_l, out_data_l, out_idx_l, out_last_l,
                               W'(w >> (8 * k)), k, (k == 3));
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid_l !== 1'b0) begin
         errors++; $display("FAIL single_after: got out_valid=%b expected 0", out_valid_l);
      end
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL single_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL single_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_msb_partial();
      logic [W-1:0] want [2];
      want[0] = 8'h11; want[1] = 8'h22;
      tick();
      in_valid = 1'b1; in_data = 32'h11223344; in_nbeats_m1 = 2'd1; in_last = 1'b0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid_m !== 1'b1 || out_data_m !== want[k] || out_idx_m !== CW'(k) || out_last_m !== 1'b0) begin
            errors++; $display("FAIL msb_beat%0d: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=0",
                               k, out_valid_m, out_data_m, out_idx_m, out_last_m, want[k], k);
         end
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL msb_ready_last_beat: got %b expected 1", in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid_m !== 1'b0) begin
         errors++; $display("FAIL msb_extra_beat: got out_valid=%b expected 0", out_valid_m);
      end
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL msb_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL msb_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      tick();
      in_valid = 1'b1; in_data = 32'h03020100; in_nbeats_m1 = 2'd3; in_last = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_accept1: got %b expected 1", in_ready);
      end
      tick();
      in_data = 32'h07060504; in_last = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid_l !== 1'b1 || out_data_l !== W'(k) || out_idx_l !== CW'(k % 4)) begin
            errors++; $display("FAIL b2b_beat%0d: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                               k, out_valid_l, out_data_l, out_idx_l, W'(k), k % 4);
         end
         if (k < 4) begin
            checks++;
            if (in_ready !== (k == 3)) begin
               errors++; $display("FAIL b2b_ready%0d: got %b expected %b", k, in_ready, (k == 3));
            end
         end
         if (k == 3) begin
            tick();
            in_valid = 1'b0;
         end
      end
      tick();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!out_valid_l) break;
      end
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL b2b_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_backpressure();
      logic [W*R-1:0] w;
      logic           pat [8];
      int             k;
      int             c;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      w = 32'hDDCCBBAA;
      tick();
      in_valid = 1'b1; in_data = w; in_nbeats_m1 = 2'd3; in_last = 1'b1; out_ready = 1'b1;
      tick();
      in_data = 32'h44332211; in_last = 1'b0;
      k = 0; c = 0;
      while (k < 4 && c < 20) begin
         out_ready = pat[c % 8];
         @(negedge clk);
         checks++;
         if (out_valid_l !== 1'b1 || out_data_l !== W'(w >> (8 * k)) || out_idx_l !== CW'(k)) begin
            errors++; $display("FAIL bp_beat c%0d: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                               c, out_valid_l, out_data_l, out_idx_l, W'(w >> (8 * k)), k);
         end
         checks++;
         if (in_ready !== (out_ready && k == 3)) begin
            errors++; $display("FAIL bp_ready c%0d: got %b expected %b", c, in_ready, (out_ready && k == 3));
         end
         if (out_ready) k++;
         tick();
         c++;
      end
      checks++;
      if (k < 4) begin
         errors++; $display("FAIL bp_timeout: got %0d beats expected 4", k);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!out_valid_l) break;
      end
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL bp_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      tick();
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_nbeats_m1 = 2'd3; in_last = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (out_data_l !== 8'hBB) begin
         errors++; $display("FAIL rmid_bb: got %h expected bb", out_data_l);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid_l !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL rmid_during: got v=%b r=%b expected 0 0", out_valid_l, in_ready);
      end
      tick();
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (out_valid_l !== 1'b0) begin
            errors++; $display("FAIL rmid_stale_beat: got out_valid=%b d=%h expected 0", out_valid_l, out_data_l);
         end
      end
      tick();
      in_valid = 1'b1; in_data = 32'h55667788; in_nbeats_m1 = 2'd2; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid_l !== 1'b1 || out_idx_l !== 2'd0 || out_data_l !== 8'h88) begin
         errors++; $display("FAIL rmid_next_word: got v=%b i=%0d d=%h expected v=1 i=0 d=88",
                            out_valid_l, out_idx_l, out_data_l);
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!out_valid_l) break;
      end
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rmid_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rmid_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      logic        acc;
      logic        stall;
      logic [21:0] snap;
      stall = 1'b0; snap = '0;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (stall) begin
            checks++;
            if ({out_valid_l, out_data_l, out_idx_l, out_last_l, out_data_m} !== {1'b1, snap[21:11], snap[10:3]}) begin
               errors++; $display("FAIL rand_hold c%0d: got d=%h i=%0d expected held beat %h",
                                  c, out_data_l, out_idx_l, snap);
            end
         end
         stall = out_valid_l && !out_ready;
         snap  = {out_data_l, out_idx_l, out_last_l, out_data_m, out_idx_m, out_last_m};
         acc   = in_valid && in_ready;
         tick();
         if (!in_valid || acc) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = $urandom;
            in_nbeats_m1 = CW'($urandom);
            in_last      = 1'($urandom);
         end
         out_ready = (c > 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      in_valid = in_valid && !acc;
      for (int n = 0; n < 20 && in_valid; n++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      out_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!out_valid_l && !in_valid) break;
      end
      #1;
      checks++;
      if (out_valid_l !== 1'b0 || in_valid) begin
         errors++; $display("FAIL rand_drain: got out_valid=%b in_valid=%b expected 0 0", out_valid_l, in_valid);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_single_full();
      test_msb_partial();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
      $fatal(1, "watchdog");
   end

endmodule
